// File: rtl/seq_chunk_adder.sv
// Multi-cycle ripple adder: adds WIDTH-bit operands CHUNK bits per clock, carry kept in a register.
// Optional subtract mode via `define SEQ_ADDER_SUB_EN (adds a Sub input port).
module seq_chunk_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
`ifdef SEQ_ADDER_SUB_EN
   input  logic             Sub,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
   end

   typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic              carry_q, carry_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  s_q, s_d;
   logic              cout_q, cout_d;
   logic              out_valid_q, out_valid_d;
   logic [CHUNK:0]    chunk_sum;
   int unsigned       base;

   assign in_ready  = (state_q == StIdle) && !rst;
   assign S         = s_q;
   assign Cout      = cout_q;
   assign out_valid = out_valid_q;

   always_comb begin
      base      = CHUNK * 32'(cnt_q);
      chunk_sum = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry_q};
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      carry_d     = carry_q;
      cnt_d       = cnt_q;
      s_d         = s_q;
      cout_d      = cout_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = A;
               cnt_d   = '0;
               state_d = StAdd;
`ifdef SEQ_ADDER_SUB_EN
               // Subtraction as A + ~B + 1; Cin is ignored in that mode
               b_d     = Sub ? ~B : B;
               carry_d = Sub ? 1'b1 : Cin;
`else
               b_d     = B;
               carry_d = Cin;
`endif
            end
         end
         StAdd: begin
            s_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
            carry_d            = chunk_sum[CHUNK];
            cnt_d              = cnt_q + CW'(1);
            if (cnt_q == CW'(NCHUNK - 1)) begin
               cout_d      = chunk_sum[CHUNK];
               out_valid_d = 1'b1;
               state_d     = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         s_q         <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         carry_q     <= carry_d;
         cnt_q       <= cnt_d;
         s_q         <= s_d;
         cout_q      <= cout_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule
